// File: rtl/trace_pkg.sv
// Shared encodings for the trace checker: FSM states and channel indices.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Channel positions inside one observation word (channel 0 in the LSBs)
  localparam int CH_Q    = 0;
  localparam int CH_TEST = 1;
  localparam int CH_IMM  = 2;

endpackage

// File: rtl/trace_fifo.sv
// Single-clock synchronous FIFO holding expected trace entries.
// The head entry is presented combinationally from the storage array.
module trace_fifo #(
  parameter int W     = 100,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem[rd_ptr_q];

  // Next pointers and fill level; a full queue refuses pushes, an empty one refuses pops
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  // Control state, cleared by the active-low synchronous reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; a push in the reset cycle is dropped
  always_ff @(posedge clock) begin
    if (reset && do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/trace_checker.sv
// Trace checker: compares processor observation strobes against a queue of
// expected entries with per-channel masks and bubble entries, counts
// mismatches and captures the first one.
module trace_checker
  import trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 3,
  parameter int DEPTH       = 16,
  parameter int ERR_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       exp_valid,
  input  logic [NUM_CH*DATA_W-1:0]   exp_data,
  input  logic [NUM_CH-1:0]          exp_mask,
  input  logic                       exp_skip,
  output logic                       exp_ready,
  input  logic                       obs_valid,
  input  logic [NUM_CH*DATA_W-1:0]   obs_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [ERR_W-1:0]           err_count,
  output logic                       first_err_valid,
  output logic [15:0]                first_err_idx,
  output logic [NUM_CH-1:0]          first_err_ch,
  output logic                       underflow,
  output logic [1:0]                 state
);

  localparam int DW = NUM_CH * DATA_W;
  localparam int EW = DW + NUM_CH + 1;

  // Saturating increment so a long failing run never wraps back to a small count
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [EW-1:0]     head;
  logic [DW-1:0]     head_data;
  logic [NUM_CH-1:0] head_mask;
  logic              head_skip;
  logic              fifo_full, fifo_empty, pop_c;
  logic [NUM_CH-1:0] mism;

  state_t            state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [15:0]       first_err_idx_q, first_err_idx_d;
  logic [NUM_CH-1:0] first_err_ch_q, first_err_ch_d;
  logic              underflow_q, underflow_d;

  trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .LW    ($clog2(DEPTH) + 1)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (exp_valid),
    .pop   (pop_c),
    .wdata ({exp_skip, exp_mask, exp_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign head_data       = head[DW-1:0];
  assign head_mask       = head[DW +: NUM_CH];
  assign head_skip       = head[EW-1];
  assign exp_ready       = ~fifo_full;
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_ch    = first_err_ch_q;
  assign underflow       = underflow_q;
  assign state           = state_q;

  // Per-channel mismatch of the observation against the queue head, masked
  always_comb begin
    mism = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mism[c] = head_mask[c] & (obs_data[c*DATA_W +: DATA_W] != head_data[c*DATA_W +: DATA_W]);
    end
  end

  // FSM next state, queue pop, error counting and first-mismatch capture
  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_ch_d    = first_err_ch_q;
    underflow_d       = underflow_q;
    pop_c             = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (obs_valid) begin
          if (fifo_empty) begin
            // No bypass: a same-cycle push cannot satisfy this observation
            underflow_d = 1'b1;
          end else begin
            pop_c = 1'b1;
            idx_d = idx_q + 16'd1;
            if (!head_skip && (mism != '0)) begin
              err_count_d = sat_inc(err_count_q);
              if (!first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_idx_d   = idx_q;
                first_err_ch_d    = mism;
              end
              if (STOP_ON_ERR != 0) state_d = ST_HALT;
            end
          end
        end
      end
      ST_HALT: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Checker state registers with active-low synchronous reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      idx_q             <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      first_err_ch_q    <= '0;
      underflow_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_ch_q    <= first_err_ch_d;
      underflow_q       <= underflow_d;
    end
  end

endmodule

// File: tb/tb_trace_checker.sv
// Testbench for trace_checker: per-cycle vector table plus hand-written
// sequences for queue fill, STOP_ON_ERR halting and mid-run reset.
module tb_trace_checker;
  import trace_pkg::*;

  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          rst_n, start, ev, es, ov;
  logic [DW-1:0] ed, od;
  logic [2:0]    em;

  logic          rdy_a, fev_a, uf_a;
  logic [4:0]    lvl_a;
  logic [15:0]   ec_a, fidx_a;
  logic [2:0]    fch_a;
  logic [1:0]    st_a;

  logic          rdy_b, fev_b, uf_b;
  logic [4:0]    lvl_b;
  logic [15:0]   ec_b, fidx_b;
  logic [2:0]    fch_b;
  logic [1:0]    st_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trace_checker #(.STOP_ON_ERR(0)) u_dut (
    .clock(clk), .reset(rst_n), .start(start),
    .exp_valid(ev), .exp_data(ed), .exp_mask(em), .exp_skip(es), .exp_ready(rdy_a),
    .obs_valid(ov), .obs_data(od), .level(lvl_a), .err_count(ec_a),
    .first_err_valid(fev_a), .first_err_idx(fidx_a), .first_err_ch(fch_a),
    .underflow(uf_a), .state(st_a)
  );

  trace_checker #(.STOP_ON_ERR(1)) u_dut_stop (
    .clock(clk), .reset(rst_n), .start(start),
    .exp_valid(ev), .exp_data(ed), .exp_mask(em), .exp_skip(es), .exp_ready(rdy_b),
    .obs_valid(ov), .obs_data(od), .level(lvl_b), .err_count(ec_b),
    .first_err_valid(fev_b), .first_err_idx(fidx_b), .first_err_ch(fch_b),
    .underflow(uf_b), .state(st_b)
  );

  typedef struct {
    logic          rst_n, start, ev;
    logic [DW-1:0] ed;
    logic [2:0]    em;
    logic          es, ov;
    logic [DW-1:0] od;
    logic [4:0]    lvl;
    logic [15:0]   ec;
    logic          fev;
    logic [15:0]   fidx;
    logic [2:0]    fch;
    logic          uf;
    logic [1:0]    st;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] pk(input logic [31:0] q, input logic [31:0] t, input logic [31:0] i);
    logic [DW-1:0] r;
    r = '0;
    r[CH_Q*32 +: 32]    = q;
    r[CH_TEST*32 +: 32] = t;
    r[CH_IMM*32 +: 32]  = i;
    return r;
  endfunction

  function automatic vec_t v(input logic r, input logic s, input logic e, input logic [DW-1:0] d,
                             input logic [2:0] m, input logic k, input logic o, input logic [DW-1:0] od_i,
                             input logic [4:0] l, input logic [15:0] c, input logic f, input logic [15:0] fi,
                             input logic [2:0] fc, input logic u, input logic [1:0] st_i);
    vec_t x;
    x.rst_n = r; x.start = s; x.ev = e; x.ed = d; x.em = m; x.es = k; x.ov = o; x.od = od_i;
    x.lvl = l; x.ec = c; x.fev = f; x.fidx = fi; x.fch = fc; x.uf = u; x.st = st_i;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic check_all(input bit inst_b, input string tag, input logic [4:0] l, input logic [15:0] c,
                           input logic f, input logic [15:0] fi, input logic [2:0] fc,
                           input logic u, input logic [1:0] s);
    if (!inst_b) begin
      chk({tag, ".level"}, 32'(lvl_a), 32'(l));
      chk({tag, ".exp_ready"}, 32'(rdy_a), 32'(l != 5'd16));
      chk({tag, ".err_count"}, 32'(ec_a), 32'(c));
      chk({tag, ".first_err_valid"}, 32'(fev_a), 32'(f));
      chk({tag, ".first_err_idx"}, 32'(fidx_a), 32'(fi));
      chk({tag, ".first_err_ch"}, 32'(fch_a), 32'(fc));
      chk({tag, ".underflow"}, 32'(uf_a), 32'(u));
      chk({tag, ".state"}, 32'(st_a), 32'(s));
    end else begin
      chk({tag, ".stop.level"}, 32'(lvl_b), 32'(l));
      chk({tag, ".stop.exp_ready"}, 32'(rdy_b), 32'(l != 5'd16));
      chk({tag, ".stop.err_count"}, 32'(ec_b), 32'(c));
      chk({tag, ".stop.first_err_valid"}, 32'(fev_b), 32'(f));
      chk({tag, ".stop.first_err_idx"}, 32'(fidx_b), 32'(fi));
      chk({tag, ".stop.first_err_ch"}, 32'(fch_b), 32'(fc));
      chk({tag, ".stop.underflow"}, 32'(uf_b), 32'(u));
      chk({tag, ".stop.state"}, 32'(st_b), 32'(s));
    end
  endtask

  // Drive one cycle of inputs, then wait until just after the next rising edge
  task automatic step(input logic r, input logic s, input logic e, input logic [DW-1:0] d,
                      input logic [2:0] m, input logic k, input logic o, input logic [DW-1:0] od_i);
    rst_n = r; start = s; ev = e; ed = d; em = m; es = k; ov = o; od = od_i;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] A, B, Bx, S, C, G, Dv, Dx, E, Ex, F, Fx, H, M, N, Mx, Z, J;

  initial begin
    rst_n = 1'b0; start = 1'b0; ev = 1'b0; ed = '0; em = '0; es = 1'b0; ov = 1'b0; od = '0;
    A  = pk(32'h28400005, 32'd0, 32'd5);
    B  = pk(32'h00C22000, 32'd5, 32'd3);
    Bx = pk(32'h00C22000, 32'd6, 32'd3);
    S  = pk(32'h0000DEAD, 32'd1, 32'd1);
    C  = pk(32'h2D008000, 32'd0, 32'd32768);
    J  = pk(32'h12345678, 32'hFFFF, 32'hABCD);
    Dv = pk(32'd1, 32'd2, 32'd3);
    Dx = pk(32'd1, 32'd2, 32'd4);
    E  = pk(32'hAAAA0000, 32'd1, 32'd2);
    Ex = pk(32'hAAAA0000, 32'd9, 32'd9);
    F  = pk(32'd5, 32'd6, 32'd7);
    Fx = pk(32'h99, 32'h99, 32'd7);
    G  = pk(32'h77, 32'd0, 32'd0);
    H  = pk(32'h10, 32'h20, 32'h30);
    M  = pk(32'd1, 32'd1, 32'd1);
    Mx = pk(32'd1, 32'd1, 32'd0);
    N  = pk(32'd2, 32'd2, 32'd2);
    Z  = '0;

    //          rst s  ev data m     sk ov obs   | lvl ec fev fidx fch   uf st
    tbl.push_back(v(0, 0, 0, Z,  3'b000, 0, 0, Z,  0, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(1, 0, 1, A,  3'b111, 0, 0, Z,  1, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(1, 1, 0, Z,  3'b000, 0, 0, Z,  1, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, A,  0, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(0, 0, 0, Z,  3'b000, 0, 0, Z,  0, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(1, 1, 0, Z,  3'b000, 0, 0, Z,  0, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 1, B,  3'b111, 0, 0, Z,  1, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, Bx, 0, 1, 1, 0, 3'b010, 0, 1));
    tbl.push_back(v(1, 0, 1, B,  3'b111, 0, 0, Z,  1, 1, 1, 0, 3'b010, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, Bx, 0, 2, 1, 0, 3'b010, 0, 1));
    tbl.push_back(v(0, 0, 0, Z,  3'b000, 0, 0, Z,  0, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(1, 1, 0, Z,  3'b000, 0, 0, Z,  0, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 1, S,  3'b111, 1, 0, Z,  1, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 1, C,  3'b111, 0, 0, Z,  2, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, J,  1, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, C,  0, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 1, Dv, 3'b111, 0, 0, Z,  1, 0, 0, 0, 3'b000, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, Dx, 0, 1, 1, 2, 3'b100, 0, 1));
    tbl.push_back(v(1, 0, 1, E,  3'b001, 0, 0, Z,  1, 1, 1, 2, 3'b100, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, Ex, 0, 1, 1, 2, 3'b100, 0, 1));
    tbl.push_back(v(1, 0, 1, F,  3'b100, 0, 0, Z,  1, 1, 1, 2, 3'b100, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, Fx, 0, 1, 1, 2, 3'b100, 0, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, Z,  0, 1, 1, 2, 3'b100, 1, 1));
    tbl.push_back(v(1, 0, 1, G,  3'b111, 0, 1, G,  1, 1, 1, 2, 3'b100, 1, 1));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, G,  0, 1, 1, 2, 3'b100, 1, 1));
    tbl.push_back(v(1, 1, 0, Z,  3'b000, 0, 0, Z,  0, 1, 1, 2, 3'b100, 1, 1));
    tbl.push_back(v(0, 0, 0, Z,  3'b000, 0, 0, Z,  0, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(1, 0, 1, A,  3'b111, 0, 1, A,  1, 0, 0, 0, 3'b000, 0, 0));
    tbl.push_back(v(1, 0, 0, Z,  3'b000, 0, 1, J,  1, 0, 0, 0, 3'b000, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[r]) begin
      step(tbl[r].rst_n, tbl[r].start, tbl[r].ev, tbl[r].ed, tbl[r].em, tbl[r].es, tbl[r].ov, tbl[r].od);
      check_all(1'b0, $sformatf("row%0d", r), tbl[r].lvl, tbl[r].ec, tbl[r].fev,
                tbl[r].fidx, tbl[r].fch, tbl[r].uf, tbl[r].st);
    end

    // Queue fill to DEPTH, overflow push, push+pop at level 15, full drain
    step(0, 0, 0, Z, 3'b000, 0, 0, Z);
    step(1, 1, 0, Z, 3'b000, 0, 0, Z);
    for (int i = 0; i < 16; i++) step(1, 0, 1, H, 3'b111, 0, 0, Z);
    check_all(1'b0, "fill16", 16, 0, 0, 0, 3'b000, 0, 1);
    step(1, 0, 1, H, 3'b111, 0, 0, Z);
    check_all(1'b0, "push17", 16, 0, 0, 0, 3'b000, 0, 1);
    step(1, 0, 0, Z, 3'b000, 0, 1, H);
    check_all(1'b0, "pop_to15", 15, 0, 0, 0, 3'b000, 0, 1);
    step(1, 0, 1, H, 3'b111, 0, 1, H);
    check_all(1'b0, "pushpop15", 15, 0, 0, 0, 3'b000, 0, 1);
    for (int i = 0; i < 15; i++) step(1, 0, 0, Z, 3'b000, 0, 1, H);
    check_all(1'b0, "drain", 0, 0, 0, 0, 3'b000, 0, 1);
    step(1, 0, 0, Z, 3'b000, 0, 1, H);
    check_all(1'b0, "drain_uf", 0, 0, 0, 0, 3'b000, 1, 1);

    // STOP_ON_ERR instance: halt on mismatch, ignore observations, restart
    step(0, 0, 0, Z, 3'b000, 0, 0, Z);
    step(1, 1, 1, M, 3'b111, 0, 0, Z);
    step(1, 0, 1, N, 3'b111, 0, 0, Z);
    check_all(1'b1, "stop_load", 2, 0, 0, 0, 3'b000, 0, 1);
    step(1, 0, 0, Z, 3'b000, 0, 1, Mx);
    check_all(1'b1, "stop_err", 1, 1, 1, 0, 3'b100, 0, 2);
    step(1, 0, 0, Z, 3'b000, 0, 1, N);
    check_all(1'b1, "halt_obs", 1, 1, 1, 0, 3'b100, 0, 2);
    step(1, 0, 1, N, 3'b111, 0, 0, Z);
    check_all(1'b1, "halt_push", 2, 1, 1, 0, 3'b100, 0, 2);
    step(1, 1, 0, Z, 3'b000, 0, 0, Z);
    check_all(1'b1, "restart", 2, 1, 1, 0, 3'b100, 0, 1);
    step(1, 0, 0, Z, 3'b000, 0, 1, N);
    check_all(1'b1, "run_again", 1, 1, 1, 0, 3'b100, 0, 1);

    // Mid-run reset with level 5 and err_count 3
    step(0, 0, 0, Z, 3'b000, 0, 0, Z);
    step(1, 1, 0, Z, 3'b000, 0, 0, Z);
    for (int i = 0; i < 8; i++) step(1, 0, 1, M, 3'b111, 0, 0, Z);
    for (int i = 0; i < 3; i++) step(1, 0, 0, Z, 3'b000, 0, 1, Mx);
    check_all(1'b0, "pre_reset", 5, 3, 1, 0, 3'b100, 0, 1);
    step(0, 1, 1, M, 3'b111, 0, 1, Mx);
    check_all(1'b0, "mid_reset", 0, 0, 0, 0, 3'b000, 0, 0);
    step(1, 0, 0, Z, 3'b000, 0, 1, Mx);
    check_all(1'b0, "post_reset", 0, 0, 0, 0, 3'b000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Synthesisable, parametrised self-checker for the processor skeleton.
- Holds a queue of expected per-cycle observations: instruction word q, ALU_reg_test, ALU_reg_imm, or any NUM_CH values.
- Compares each observation strobe from the processor domain against the queue head, with per-channel don't-care masks and bubble entries for taken jumps/branches.
- Counts errors and captures the first mismatch, so FPGA runs and simulation share one checker.

Parameters:
DATA_W, 32, width of one observed channel
NUM_CH, 3, number of channels compared per observation
DEPTH, 16, expected-entry queue depth (power of two, >=2)
ERR_W, 16, error counter width
STOP_ON_ERR, 0, 1 = halt checking at first mismatch

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-low reset
start  in  1  pulse: IDLE -> RUN
exp_valid  in  1  expected entry offered
exp_data  in  NUM_CH*DATA_W  expected values, channel 0 in LSBs
exp_mask  in  NUM_CH  1 = compare channel, 0 = don't care
exp_skip  in  1  entry is a bubble: consumed, never compared
exp_ready  out  1  queue not full
obs_valid  in  1  one-cycle strobe: processor completed a cycle
obs_data  in  NUM_CH*DATA_W  observed values
level  out  clog2(DEPTH)+1  queued entries
err_count  out  ERR_W  mismatching observations, saturating
first_err_valid  out  1  sticky, first mismatch captured
first_err_idx  out  16  trace index of first mismatch
first_err_ch  out  NUM_CH  mismatching-channel bitmask of first mismatch
underflow  out  1  sticky: obs_valid seen in RUN with queue empty
state  out  2  IDLE=0, RUN=1, HALT=2

Behaviour:
- Reset (reset==0 at posedge): queue emptied, pointers/level=0, trace index=0, err_count=0, first_err_*=0, underflow=0, state=IDLE, exp_ready=1. This applies mid-operation and discards any same-cycle push or observation.
- Push: exp_valid & exp_ready writes {data, mask, skip}. exp_ready = (level != DEPTH). Pushes are accepted in every state.
- IDLE: observations ignored, queue untouched. start -> RUN.
- RUN, obs_valid, queue empty: underflow<=1, no pop, index unchanged, no error count.
- RUN, obs_valid, queue non-empty: pop head, index += 1 (wraps at 2^16).
  - skip=1: no compare.
  - Otherwise mism[c] = mask[c] & (obs[c] != exp[c]).
  - If mism != 0: err_count += 1 (holds at 2^ERR_W-1). If first_err_valid==0, capture index (pre-increment) and mism, and set first_err_valid.
  - If STOP_ON_ERR and mism != 0, next state = HALT.
- HALT: no pops, no compares; pushes still accepted. start -> RUN; captured error info is kept.
- start while already RUN: no effect.
- Simultaneous push and pop: level unchanged. Both occur if the queue is non-empty and not full. On an empty queue the pop is not satisfied by the same-cycle push (no bypass) and underflow is set.
- All outputs are registered. Compare results are visible the cycle after obs_valid. level and exp_ready update the cycle after push/pop.

Decomposition:
- Shared package trace_pkg holds the state encodings (ST_IDLE, ST_RUN, ST_HALT) and the channel index constants CH_Q=0, CH_TEST=1, CH_IMM=2.
- One sub-module, trace_fifo: synchronous single-clock FIFO of width NUM_CH*DATA_W+NUM_CH+1 with full/empty/level.
- trace_checker contains the FSM, compare, and counters.

Test Plan:
- Reset, push {q=0x28400005, test=0, imm=5} mask 111, start, obs identical -> err_count=0, level 1->0, first_err_valid=0, index=1.
- Push {q=0x00C22000, test=5, imm=3}, obs test=6 -> err_count=1, first_err_idx=0, first_err_ch=010. A second mismatch -> err_count=2, captured info unchanged.
- Push a skip entry, then a full-mask entry {0x2D008000, 0, 32768}; obs garbage then matching obs -> err_count=0, index=2.
- Mask 100 with obs ALU values differing -> no error. Obs in RUN with empty queue -> underflow=1, err_count unchanged.
- Fill DEPTH=16 entries -> exp_ready=0, 17th push ignored. Simultaneous push+obs at level 15 -> level stays 15. STOP_ON_ERR=1 with a mismatch -> state=HALT, later obs ignored, start -> RUN.
- Assert reset mid-RUN with level 5 and err_count 3 -> next cycle all outputs at reset values, state=IDLE.
